// File: rtl/uart_rx_core_if.sv
// Serial-line and received-word bundle between the pad side and the UART receiver core.
// The slave modport belongs to the receiver; the master side drives the line and consumes words.
interface uart_rx_core_if #(
    parameter int unsigned DATA_WD = 8
);
    logic               RX_IN;
    logic               PAR_EN;
    logic               PAR_TYP;
    logic [DATA_WD-1:0] P_DATA;
    logic               DATA_VALID;
    logic               PAR_ERR;
    logic               STP_ERR;
    logic               Busy;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled start/data/parity/stop recovery with one-cycle result pulses.
// Define UART_RX_MAJ_VOTE_EN to take each bit as a 2-of-3 vote around the bit centre.
module uart_rx_core #(
    parameter int unsigned DATA_WD  = 8,
    parameter int unsigned PRESCALE = 8
) (
    input logic           CLK,
    input logic           RST,
    uart_rx_core_if.slave bus
);
    localparam int unsigned EW = $clog2(PRESCALE);
    localparam int unsigned BW = $clog2(DATA_WD + 1);

    localparam logic [EW-1:0] EdgeLast = EW'(PRESCALE - 1);
`ifdef UART_RX_MAJ_VOTE_EN
    localparam logic [EW-1:0] EdgePre = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] EdgeMid = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] EdgeDec = EW'(PRESCALE / 2 + 1);
`else
    localparam logic [EW-1:0] EdgeDec = EW'(PRESCALE / 2);
`endif
    localparam logic [BW-1:0] BitLast = BW'(DATA_WD - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e             state_q;
    logic [EW-1:0]      edge_cnt_q;
    logic [BW-1:0]      bit_cnt_q;
    logic [DATA_WD-1:0] shift_q;
    logic [DATA_WD-1:0] p_data_q;
    logic               valid_q;
    logic               par_err_q;
    logic               stp_err_q;
    logic               busy_q;
    logic               par_en_q;
    logic               par_typ_q;
    logic               par_fail_q;
    logic               samp;

`ifdef UART_RX_MAJ_VOTE_EN
    logic [1:0] vote_q;  // [1] sample at S-1, [0] sample at S
    assign samp = (vote_q[1] & vote_q[0]) | (vote_q[1] & bus.RX_IN) | (vote_q[0] & bus.RX_IN);
`else
    assign samp = bus.RX_IN;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            p_data_q   <= '0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_fail_q <= 1'b0;
`ifdef UART_RX_MAJ_VOTE_EN
            vote_q     <= 2'b00;
`endif
        end else begin
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
`ifdef UART_RX_MAJ_VOTE_EN
            if (edge_cnt_q == EdgePre) vote_q[1] <= bus.RX_IN;
            if (edge_cnt_q == EdgeMid) vote_q[0] <= bus.RX_IN;
`endif
            if (edge_cnt_q == EdgeLast) edge_cnt_q <= '0;
            else                        edge_cnt_q <= edge_cnt_q + 1'b1;

            case (state_q)
                StIdle: begin
                    edge_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    // The detecting cycle is edge 0 of the start bit
                    if (!bus.RX_IN) begin
                        state_q    <= StStart;
                        edge_cnt_q <= EW'(1);
                        busy_q     <= 1'b1;
                        par_en_q   <= bus.PAR_EN;
                        par_typ_q  <= bus.PAR_TYP;
                        par_fail_q <= 1'b0;
                    end
                end
                StStart: begin
                    if (edge_cnt_q == EdgeDec && samp) begin
                        state_q    <= StIdle;
                        edge_cnt_q <= '0;
                        busy_q     <= 1'b0;
                    end else if (edge_cnt_q == EdgeLast) begin
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (edge_cnt_q == EdgeDec) shift_q <= DATA_WD'({samp, shift_q} >> 1);
                    if (edge_cnt_q == EdgeLast) begin
                        if (bit_cnt_q == BitLast) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_en_q ? StParity : StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (edge_cnt_q == EdgeDec) begin
                        par_fail_q <= samp != (par_typ_q ? ~^shift_q : ^shift_q);
                    end
                    if (edge_cnt_q == EdgeLast) state_q <= StStop;
                end
                StStop: begin
                    // Leave early so IDLE can catch a back-to-back start bit
                    if (edge_cnt_q == EdgeDec) begin
                        state_q    <= StIdle;
                        edge_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        busy_q     <= 1'b0;
                        if (par_fail_q) begin
                            par_err_q <= 1'b1;
                        end else if (!samp) begin
                            stp_err_q <= 1'b1;
                        end else begin
                            valid_q  <= 1'b1;
                            p_data_q <= shift_q;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.DATA_VALID = valid_q;
    assign bus.PAR_ERR    = par_err_q;
    assign bus.STP_ERR    = stp_err_q;
    assign bus.Busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frames are driven on negedges, outputs sampled on negedges.
// Expected values are hand-derived from the frame layout; the vote build is selected by macro.
module tb_uart_rx_core;
    localparam int P = 8;
    localparam int S = P / 2;
`ifdef UART_RX_MAJ_VOTE_EN
    localparam int DEC = S + 1;
`else
    localparam int DEC = S;
`endif
    // Busy cycles: start edges 1..P-1, data bits, stop edges 0..DEC
    localparam int BUSY_NOPAR = (P - 1) + 8 * P + DEC + 1;
    localparam int BUSY_PAR   = BUSY_NOPAR + P;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    uart_rx_core_if #(.DATA_WD(8)) u_if ();

    uart_rx_core #(.DATA_WD(8), .PRESCALE(P)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (u_if)
    );

    int n_cmp = 0;
    int n_fail = 0;

    int n_dv = 0, n_pe = 0, n_se = 0, n_busy = 0, n_ovl = 0;
    logic [7:0] seen_q[$];

    always @(negedge CLK) begin
        if (u_if.DATA_VALID) begin
            n_dv++;
            seen_q.push_back(u_if.P_DATA);
        end
        if (u_if.PAR_ERR) n_pe++;
        if (u_if.STP_ERR) n_se++;
        if (u_if.Busy) n_busy++;
        if ((u_if.DATA_VALID || u_if.PAR_ERR || u_if.STP_ERR) && u_if.Busy) n_ovl++;
    end

    int dv0, pe0, se0, busy0, ovl0, q0;

    task automatic snap();
        dv0 = n_dv; pe0 = n_pe; se0 = n_se; busy0 = n_busy; ovl0 = n_ovl; q0 = seen_q.size();
    endtask

    task automatic idle(input int n);
        u_if.RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bit(input logic b);
        u_if.RX_IN = b;
        repeat (P) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit has_par, input logic par_bit,
                              input logic stop_bit, input bit flip_cfg);
        logic en_s, typ_s;
        en_s = u_if.PAR_EN;
        typ_s = u_if.PAR_TYP;
        send_bit(1'b0);
        if (flip_cfg) begin
            u_if.PAR_EN = ~en_s;
            u_if.PAR_TYP = ~typ_s;
        end
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (has_par) send_bit(par_bit);
        send_bit(stop_bit);
        u_if.RX_IN = 1'b1;
        u_if.PAR_EN = en_s;
        u_if.PAR_TYP = typ_s;
    endtask

    task automatic test_reset();
        u_if.RX_IN = 1'b1;
        u_if.PAR_EN = 1'b0;
        u_if.PAR_TYP = 1'b0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (u_if.P_DATA !== 8'h00) begin
            n_fail++; $display("FAIL reset_p_data: got %h want 00", u_if.P_DATA);
        end
        n_cmp++;
        if (u_if.DATA_VALID !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", u_if.DATA_VALID);
        end
        n_cmp++;
        if ({u_if.PAR_ERR, u_if.STP_ERR} !== 2'b00) begin
            n_fail++; $display("FAIL reset_errs: got %b%b want 00", u_if.PAR_ERR, u_if.STP_ERR);
        end
        n_cmp++;
        if (u_if.Busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", u_if.Busy);
        end
        RST = 1'b0;
        idle(4);
    endtask

    task automatic test_no_parity();
        u_if.PAR_EN = 1'b0;
        snap();
        send_frame(8'hA3, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        n_cmp++;
        if (n_dv - dv0 !== 1 || n_pe - pe0 !== 0 || n_se - se0 !== 0) begin
            n_fail++;
            $display("FAIL nopar_pulses: got dv=%0d pe=%0d se=%0d want 1 0 0",
                     n_dv - dv0, n_pe - pe0, n_se - se0);
        end
        n_cmp++;
        if (u_if.P_DATA !== 8'hA3) begin
            n_fail++; $display("FAIL nopar_data: got %h want a3", u_if.P_DATA);
        end
        n_cmp++;
        if (n_busy - busy0 !== BUSY_NOPAR) begin
            n_fail++; $display("FAIL nopar_busy: got %0d want %0d", n_busy - busy0, BUSY_NOPAR);
        end
        n_cmp++;
        if (n_ovl - ovl0 !== 0) begin
            n_fail++; $display("FAIL nopar_busy_at_pulse: got %0d want 0", n_ovl - ovl0);
        end
    endtask

    task automatic test_parity_ok();
        u_if.PAR_EN = 1'b1;
        u_if.PAR_TYP = 1'b0;
        snap();
        send_frame(8'hB4, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);
        n_cmp++;
        if (u_if.P_DATA !== 8'hB4) begin
            n_fail++; $display("FAIL even_par_data: got %h want b4", u_if.P_DATA);
        end
        u_if.PAR_TYP = 1'b1;
        send_frame(8'hD2, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(3);
        n_cmp++;
        if (n_dv - dv0 !== 2 || n_pe - pe0 !== 0 || n_se - se0 !== 0) begin
            n_fail++;
            $display("FAIL par_ok_pulses: got dv=%0d pe=%0d se=%0d want 2 0 0",
                     n_dv - dv0, n_pe - pe0, n_se - se0);
        end
        n_cmp++;
        if (u_if.P_DATA !== 8'hD2) begin
            n_fail++; $display("FAIL odd_par_data: got %h want d2", u_if.P_DATA);
        end
        n_cmp++;
        if (n_busy - busy0 !== 2 * BUSY_PAR) begin
            n_fail++; $display("FAIL par_busy: got %0d want %0d", n_busy - busy0, 2 * BUSY_PAR);
        end
    endtask

    task automatic test_parity_err();
        u_if.PAR_EN = 1'b1;
        u_if.PAR_TYP = 1'b0;
        snap();
        send_frame(8'hB4, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(3);
        n_cmp++;
        if (n_dv - dv0 !== 0 || n_pe - pe0 !== 1 || n_se - se0 !== 0) begin
            n_fail++;
            $display("FAIL par_err_pulses: got dv=%0d pe=%0d se=%0d want 0 1 0",
                     n_dv - dv0, n_pe - pe0, n_se - se0);
        end
        n_cmp++;
        if (u_if.P_DATA !== 8'hD2) begin
            n_fail++; $display("FAIL par_err_hold: got %h want d2", u_if.P_DATA);
        end
    endtask

    task automatic test_cfg_latch();
        // Config flips right after the start bit; the frame must still use parity-even
        u_if.PAR_EN = 1'b1;
        u_if.PAR_TYP = 1'b0;
        snap();
        send_frame(8'h96, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(3);
        n_cmp++;
        if (n_dv - dv0 !== 1 || n_pe - pe0 !== 0 || n_se - se0 !== 0) begin
            n_fail++;
            $display("FAIL cfg_latch_pulses: got dv=%0d pe=%0d se=%0d want 1 0 0",
                     n_dv - dv0, n_pe - pe0, n_se - se0);
        end
        n_cmp++;
        if (u_if.P_DATA !== 8'h96) begin
            n_fail++; $display("FAIL cfg_latch_data: got %h want 96", u_if.P_DATA);
        end
    endtask

    task automatic test_stop_err();
        u_if.PAR_EN = 1'b0;
        snap();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2 * P);
        n_cmp++;
        if (n_dv - dv0 !== 0 || n_pe - pe0 !== 0 || n_se - se0 !== 1) begin
            n_fail++;
            $display("FAIL stp_err_pulses: got dv=%0d pe=%0d se=%0d want 0 0 1",
                     n_dv - dv0, n_pe - pe0, n_se - se0);
        end
        n_cmp++;
        if (u_if.P_DATA !== 8'h96) begin
            n_fail++; $display("FAIL stp_err_hold: got %h want 96", u_if.P_DATA);
        end
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        n_cmp++;
        if (u_if.P_DATA !== 8'h3C || n_dv - dv0 !== 1) begin
            n_fail++;
            $display("FAIL stp_recover: got data=%h dv=%0d want 3c 1", u_if.P_DATA, n_dv - dv0);
        end
    endtask

    task automatic test_start_glitch();
        snap();
        u_if.RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        idle(3 * P);
        n_cmp++;
        if (n_dv - dv0 !== 0 || n_pe - pe0 !== 0 || n_se - se0 !== 0) begin
            n_fail++;
            $display("FAIL glitch_pulses: got dv=%0d pe=%0d se=%0d want 0 0 0",
                     n_dv - dv0, n_pe - pe0, n_se - se0);
        end
        n_cmp++;
        if (n_busy - busy0 !== DEC) begin
            n_fail++; $display("FAIL glitch_busy: got %0d want %0d", n_busy - busy0, DEC);
        end
    endtask

    task automatic test_reset_midframe();
        u_if.PAR_EN = 1'b0;
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        u_if.RX_IN = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (u_if.Busy !== 1'b1) begin
            n_fail++; $display("FAIL midframe_busy: got %b want 1", u_if.Busy);
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_cmp++;
        if ({u_if.P_DATA, u_if.DATA_VALID, u_if.PAR_ERR, u_if.STP_ERR, u_if.Busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL midframe_reset: got data=%h dv=%b pe=%b se=%b busy=%b want all 0",
                     u_if.P_DATA, u_if.DATA_VALID, u_if.PAR_ERR, u_if.STP_ERR, u_if.Busy);
        end
        idle(P - 2 + 4 * P + 2);
        n_cmp++;
        if (n_dv - dv0 !== 0 || n_pe - pe0 !== 0 || n_se - se0 !== 0 || u_if.P_DATA !== 8'h00) begin
            n_fail++;
            $display("FAIL midframe_tail: got dv=%0d pe=%0d se=%0d data=%h want 0 0 0 00",
                     n_dv - dv0, n_pe - pe0, n_se - se0, u_if.P_DATA);
        end
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        n_cmp++;
        if (u_if.P_DATA !== 8'h81 || n_dv - dv0 !== 1) begin
            n_fail++;
            $display("FAIL after_reset_frame: got data=%h dv=%0d want 81 1", u_if.P_DATA, n_dv - dv0);
        end
    endtask

    task automatic test_back_to_back();
        u_if.PAR_EN = 1'b0;
        snap();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        n_cmp++;
        if (n_dv - dv0 !== 2 || n_pe - pe0 !== 0 || n_se - se0 !== 0) begin
            n_fail++;
            $display("FAIL b2b_pulses: got dv=%0d pe=%0d se=%0d want 2 0 0",
                     n_dv - dv0, n_pe - pe0, n_se - se0);
        end else begin
            n_cmp++;
            if (seen_q[q0] !== 8'h55 || seen_q[q0+1] !== 8'hAA) begin
                n_fail++;
                $display("FAIL b2b_data: got %h %h want 55 aa", seen_q[q0], seen_q[q0+1]);
            end
        end
    endtask

    task automatic test_centre_glitch();
        logic [7:0] exp_d;
`ifdef UART_RX_MAJ_VOTE_EN
        exp_d = 8'h00;
`else
        exp_d = 8'h04;
`endif
        u_if.PAR_EN = 1'b0;
        snap();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        // Bit 2: line low except a single-cycle high at the sample edge
        u_if.RX_IN = 1'b0;
        repeat (S) @(negedge CLK);
        u_if.RX_IN = 1'b1;
        @(negedge CLK);
        u_if.RX_IN = 1'b0;
        repeat (P - S - 1) @(negedge CLK);
        for (int i = 3; i < 8; i++) send_bit(1'b0);
        send_bit(1'b1);
        idle(3);
        n_cmp++;
        if (n_dv - dv0 !== 1) begin
            n_fail++; $display("FAIL centre_glitch_valid: got %0d want 1", n_dv - dv0);
        end
        n_cmp++;
        if (u_if.P_DATA !== exp_d) begin
            n_fail++; $display("FAIL centre_glitch_data: got %h want %h", u_if.P_DATA, exp_d);
        end
    endtask

    initial begin
        u_if.RX_IN = 1'b1;
        u_if.PAR_EN = 1'b0;
        u_if.PAR_TYP = 1'b0;
        @(negedge CLK);
        test_reset();
        test_no_parity();
        test_parity_ok();
        test_parity_err();
        test_cfg_latch();
        test_stop_err();
        test_start_glitch();
        test_reset_midframe();
        test_back_to_back();
        test_centre_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receiver; the receive-side counterpart of the team's UART transmitter.
- Recovers frames of the form: 1 start bit (0), DATA_WD data bits LSB first, optional parity bit, 1 stop bit (1).
- Oversamples RX_IN at PRESCALE clocks per bit and presents each good byte on P_DATA with a one-cycle DATA_VALID pulse.
- Reports parity and stop-bit errors as one-cycle pulses; sits between the pad-side serial line and the system-side consumer.

Parameters:
DATA_WD, 8, number of data bits per frame.
PRESCALE, 8, CLK cycles per UART bit; must be an even integer ≥ 4.

Ports:
CLK  input  1  receiver clock, PRESCALE × baud rate.
RST  input  1  synchronous, active-high reset.
RX_IN  input  1  serial line; idles at 1.
PAR_EN  input  1  1 = frame carries a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
P_DATA  output  DATA_WD  last correctly received data word.
DATA_VALID  output  1  one-cycle pulse when P_DATA is updated.
PAR_ERR  output  1  one-cycle pulse: parity mismatch.
STP_ERR  output  1  one-cycle pulse: stop bit sampled as 0.
Busy  output  1  high while a frame is being received.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high, sampled on rising CLK edges only.
- Reset values: state IDLE; edge_cnt = 0; bit_cnt = 0; P_DATA = 0; DATA_VALID = PAR_ERR = STP_ERR = Busy = 0.
- Reset has priority over everything. Reset mid-frame abandons the frame with no pulses, and P_DATA keeps its reset value 0.
- Counters:
  - edge_cnt runs 0..PRESCALE-1 within each bit.
  - Sample point S = PRESCALE/2.
  - On edge_cnt == PRESCALE-1, edge_cnt wraps to 0 and the bit ends.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - When RX_IN == 0 is seen, that cycle counts as edge 0 of the start bit.
  - Next state START with edge_cnt = 1.
  - PAR_EN and PAR_TYP are latched at this moment and held for the whole frame; mid-frame changes are ignored.
- START:
  - Sample at S.
  - If the sample is 1 (glitch): return to IDLE on the next cycle with no output pulses.
  - Otherwise: go to DATA at the end of the bit.
- DATA:
  - Sample at S and shift in LSB first; bit_cnt increments per bit.
  - After DATA_WD bits: go to PARITY if the latched PAR_EN = 1, else go to STOP.
- PARITY:
  - Expected bit = ^data for even parity, ~^data for odd parity.
  - Mismatch sets an internal par_fail flag.
  - Go to STOP at the end of the bit.
- STOP:
  - Frame decision at the stop sample (S, or S+1 when majority vote is enabled).
  - Next cycle: state returns to IDLE (edge_cnt = 0, bit_cnt = 0), and exactly one of the following holds for one cycle:
    - DATA_VALID = 1 and P_DATA updated, when the stop bit = 1 and there is no par_fail;
    - PAR_ERR = 1, when par_fail (takes precedence over a stop error);
    - STP_ERR = 1, when the stop bit = 0 and there is no par_fail.
  - On any error, P_DATA holds its previous value.
- Busy:
  - Registered; goes high the cycle after IDLE detects the start bit.
  - Goes low on the same cycle the FSM returns to IDLE.
- Back-to-back frames: a start bit arriving immediately after the stop bit's nominal end is accepted. IDLE runs during the rest of the stop bit and sees RX_IN = 1.
- Latency: DATA_VALID rises 1 cycle after the stop sample.

Optional Feature:
- Macro: UART_RX_MAJ_VOTE_EN.
- Defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of samples at edges S-1, S and S+1. The decision is made at S+1. A single-cycle glitch at the bit centre is rejected.
- Undefined: single sample at edge S, decision at S. A glitch at S corrupts the bit.
- All other timing is identical in both builds.

Test Plan:
- PAR_EN=0, send 0xA3 (line 0,1,1,0,0,0,1,0,1,1) -> one DATA_VALID pulse, P_DATA=0xA3, PAR_ERR=STP_ERR=0, Busy high for ~10×PRESCALE cycles.
- PAR_EN=1, PAR_TYP=0, send 0xB4 with parity 0, then PAR_TYP=1, send 0xD2 with parity 1 -> two DATA_VALID pulses, P_DATA=0xB4 then 0xD2, no errors.
- PAR_EN=1, PAR_TYP=0, send 0xB4 with parity bit 1 -> PAR_ERR one-cycle pulse, DATA_VALID=0, P_DATA unchanged (previous value).
- PAR_EN=0, send 0x5A with stop bit 0 -> STP_ERR pulse, DATA_VALID=0; then a valid 0x3C frame -> DATA_VALID, P_DATA=0x3C.
- RX_IN low for 2 cycles only, then high -> Busy pulses briefly then 0, no DATA_VALID/PAR_ERR/STP_ERR. Assert RST for 1 cycle at data bit 4 of a 0xFF frame -> all outputs 0 next cycle, following frame 0x81 received correctly.
- With UART_RX_MAJ_VOTE_EN, inject a 1-cycle inversion at edge S of data bit 2 of 0x00 -> P_DATA=0x00. Without the macro -> P_DATA=0x04.
